// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access codes, FSM states and the
// alignment / lane-extraction helpers used by lsu_mem.
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_code_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Misaligned halfword/word accesses and unassigned codes are all errors.
    function automatic logic access_error(input logic       we,
                                          input logic [1:0] lo,
                                          input logic [2:0] lc,
                                          input logic [1:0] sc);
        logic err;
        err = 1'b0;
        if (we) begin
            case (sc)
                ST_SB:   err = 1'b0;
                ST_SH:   err = lo[0];
                ST_SW:   err = |lo;
                default: err = 1'b1;
            endcase
        end else begin
            case (lc)
                LD_LB, LD_LBU: err = 1'b0;
                LD_LH, LD_LHU: err = lo[0];
                LD_LW:         err = |lo;
                default:       err = 1'b1;
            endcase
        end
        return err;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  lc);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (lc)
            LD_LB:   res = {{24{sh[7]}}, sh[7:0]};
            LD_LH:   res = {{16{sh[15]}}, sh[15:0]};
            LD_LBU:  res = {24'h0, sh[7:0]};
            LD_LHU:  res = {16'h0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Request/response bus between a load/store client (master) and lsu_mem (slave).
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_load_code;
    logic [1:0]  req_store_code;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_load_code, req_store_code,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_load_code, req_store_code,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_byte_ram.sv
// Word-organised byte RAM: four byte-lane write enables and a registered read
// port whose output holds until the next read enable.
module byte_ram #(
    parameter int WORDS = 256,
    parameter int WAW   = 8
) (
    input  logic           clk,
    input  logic [WAW-1:0] addr,
    input  logic [3:0]     be,
    input  logic [31:0]    wdata,
    input  logic           re,
    output logic [31:0]    rdata
);
    logic [31:0] mem [WORDS];

    // NOTE: memory and its read register have no reset; contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/lsu_mem.sv
// Single-outstanding load/store unit over a DEPTH-byte little-endian memory,
// with RD_LAT-cycle loads and one-cycle store/error responses.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    lsu_mem_if.slave  bus
);
    localparam int WORDS = DEPTH / 4;
    localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e         state, state_nx;
    logic           idle, accept, req_err;
    logic [WAW-1:0] word_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data, rd_word;
    logic           we_q, err_q;
    logic [1:0]     lane_q;
    logic [2:0]     lcode_q;

    assign idle     = (state == IDLE);
    assign accept   = bus.req_valid && idle;
    assign req_err  = access_error(bus.req_we, bus.req_addr[1:0],
                                   bus.req_load_code, bus.req_store_code);
    // Truncation to the word index drops upper address bits, giving the wrap.
    assign word_idx = (WORDS > 1) ? WAW'(bus.req_addr >> 2) : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = bus.req_wdata;
        if (accept && bus.req_we && !req_err) begin
            case (bus.req_store_code)
                ST_SB: begin
                    wr_be   = 4'b0001 << bus.req_addr[1:0];
                    wr_data = {4{bus.req_wdata[7:0]}};
                end
                ST_SH: begin
                    wr_be   = 4'b0011 << bus.req_addr[1:0];
                    wr_data = {2{bus.req_wdata[15:0]}};
                end
                default: wr_be = 4'b1111;
            endcase
        end
    end

    byte_ram #(.WORDS(WORDS), .WAW(WAW)) u_ram (
        .clk   (clk),
        .addr  (word_idx),
        .be    (wr_be),
        .wdata (wr_data),
        .re    (accept && !bus.req_we && !req_err),
        .rdata (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (bus.req_we || req_err || RD_LAT == 1) ? RESP : WAIT;
            WAIT:    state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= 2'b00;
            lcode_q <= 3'b000;
        end else if (accept) begin
            we_q    <= bus.req_we;
            err_q   <= req_err;
            lane_q  <= bus.req_addr[1:0];
            lcode_q <= bus.req_load_code;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && err_q;
    assign bus.resp_rdata = (state == RESP && !we_q && !err_q)
                          ? load_extend(rd_word, lane_q, lcode_q) : 32'h0;
endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: one instance per RD_LAT value, driven from a shared
// stimulus path, with a per-instance scoreboard of expected responses.
module tb_lsu_mem;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [7:0] mm [2][1024];

    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_lc = '0;
    logic [1:0]  req_sc = '0;

    lsu_mem_if b1();
    lsu_mem_if b2();

    assign b1.req_valid      = req_valid && (sel == 0);
    assign b2.req_valid      = req_valid && (sel == 1);
    assign b1.req_we         = req_we;
    assign b2.req_we         = req_we;
    assign b1.req_addr       = req_addr;
    assign b2.req_addr       = req_addr;
    assign b1.req_wdata      = req_wdata;
    assign b2.req_wdata      = req_wdata;
    assign b1.req_load_code  = req_lc;
    assign b2.req_load_code  = req_lc;
    assign b1.req_store_code = req_sc;
    assign b2.req_store_code = req_sc;

    lsu_mem #(.DEPTH(1024), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst_a), .bus(b1));
    lsu_mem #(.DEPTH(1024), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst_b), .bus(b2));

    function automatic logic ready_sel();
        return (sel == 0) ? b1.req_ready : b2.req_ready;
    endfunction

    function automatic logic store_err(input logic [31:0] a, input logic [1:0] sc);
        if (sc == 2'b00) return 1'b0;
        if (sc == 2'b01) return a[0];
        if (sc == 2'b10) return a[1:0] != 2'b00;
        return 1'b1;
    endfunction

    // Byte-wise reference: returns {err, data}.
    function automatic logic [32:0] model_load(input int d, input logic [31:0] a, input logic [2:0] lc);
        logic [7:0] b0, b1v, b2v, b3v;
        b0 = mm[d][a[9:0]];
        case (lc)
            3'b000: return {1'b0, {{24{b0[7]}}, b0}};
            3'b100: return {1'b0, 24'h0, b0};
            3'b001, 3'b101: begin
                if (a[0]) return {1'b1, 32'h0};
                b1v = mm[d][a[9:0] + 10'd1];
                if (lc == 3'b001) return {1'b0, {{16{b1v[7]}}, b1v, b0}};
                return {1'b0, 16'h0, b1v, b0};
            end
            3'b010: begin
                if (a[1:0] != 2'b00) return {1'b1, 32'h0};
                b1v = mm[d][a[9:0] + 10'd1];
                b2v = mm[d][a[9:0] + 10'd2];
                b3v = mm[d][a[9:0] + 10'd3];
                return {1'b0, b3v, b2v, b1v, b0};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic mon(input int d);
        logic v, e;
        logic [31:0] r;
        exp_t x;
        v = (d == 0) ? b1.resp_valid : b2.resp_valid;
        e = (d == 0) ? b1.resp_err   : b2.resp_err;
        r = (d == 0) ? b1.resp_rdata : b2.resp_rdata;
        checks++;
        if (v !== 1'b1) begin
            if (v !== 1'b0 || r !== 32'h0 || e !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs dut%0d cyc=%0d valid=%b rdata=%h err=%b, want 0/0/0", d, cyc, v, r, e);
            end
        end else if ((d == 0 && q1.size() == 0) || (d == 1 && q2.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc=%0d rdata=%h err=%b", d, cyc, r, e);
        end else begin
            x = (d == 0) ? q1.pop_front() : q2.pop_front();
            if (r !== x.rdata) begin
                errors++;
                $display("FAIL resp_rdata dut%0d got %h want %h", d, r, x.rdata);
            end
            checks++;
            if (e !== x.err) begin
                errors++;
                $display("FAIL resp_err dut%0d got %b want %b", d, e, x.err);
            end
            checks++;
            if (cyc != x.cyc) begin
                errors++;
                $display("FAIL resp_latency dut%0d got cycle %0d want %0d", d, cyc, x.cyc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon(0);
        mon(1);
    endtask

    // Called just before the accept edge: records the expectation and model update.
    task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sc, input logic [31:0] er, input logic ee);
        exp_t x;
        int lat;
        lat = (we || ee) ? 1 : ((sel == 0) ? 1 : 2);
        x.rdata = er;
        x.err   = ee;
        x.cyc   = cyc + lat;
        if (sel == 0) q1.push_back(x);
        else          q2.push_back(x);
        if (we && !ee) begin
            mm[sel][a[9:0]] = wd[7:0];
            if (sc != 2'b00) mm[sel][a[9:0] + 10'd1] = wd[15:8];
            if (sc == 2'b10) begin
                mm[sel][a[9:0] + 10'd2] = wd[23:16];
                mm[sel][a[9:0] + 10'd3] = wd[31:24];
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] lc, input logic [1:0] sc,
                         input logic [31:0] er, input logic ee);
        int budget;
        budget = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_lc = lc; req_sc = sc;
        req_valid = 1'b1;
        while (ready_sel() !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (ready_sel() !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout dut%0d addr=%h", sel, a);
            req_valid = 1'b0;
            return;
        end
        push_exp(we, a, wd, sc, er, ee);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q1.size() != 0 || q2.size() != 0) && budget < 10) begin
            tick();
            budget++;
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout pending %0d/%0d", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
        tick();
    endtask

    task automatic st(input logic [1:0] sc, input logic [31:0] a, input logic [31:0] wd, input logic ee);
        issue(1'b1, a, wd, 3'b000, sc, 32'h0, ee);
        drain();
    endtask

    task automatic ld(input logic [2:0] lc, input logic [31:0] a, input logic [31:0] er, input logic ee);
        issue(1'b0, a, 32'h0, lc, 2'b00, er, ee);
        drain();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        checks++;
        if (b1.req_ready !== 1'b1 || b2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 1/1", b1.req_ready, b2.req_ready);
        end
    endtask

    task automatic test_word_access();
        st(ST_SW, 32'h10, 32'h80FF_1234, 1'b0);
        ld(LD_LW, 32'h10, 32'h80FF_1234, 1'b0);
    endtask

    task automatic test_extend();
        ld(LD_LB,  32'h13, 32'hFFFF_FF80, 1'b0);
        ld(LD_LBU, 32'h13, 32'h0000_0080, 1'b0);
        ld(LD_LH,  32'h12, 32'hFFFF_80FF, 1'b0);
        ld(LD_LHU, 32'h12, 32'h0000_80FF, 1'b0);
    endtask

    task automatic test_errors();
        st(ST_SW, 32'h20, 32'hCAFE_F00D, 1'b0);
        st(ST_SH, 32'h21, 32'h0000_5555, 1'b1);
        st(ST_SW, 32'h22, 32'h1111_1111, 1'b1);
        st(2'b11, 32'h20, 32'h2222_2222, 1'b1);
        ld(LD_LW, 32'h20, 32'hCAFE_F00D, 1'b0);
        ld(LD_LHU, 32'h21, 32'h0, 1'b1);
        ld(LD_LW,  32'h22, 32'h0, 1'b1);
        ld(3'b011, 32'h20, 32'h0, 1'b1);
        ld(3'b111, 32'h20, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        st(ST_SB, 32'h400, 32'h0000_00AB, 1'b0);
        ld(LD_LBU, 32'h000, 32'h0000_00AB, 1'b0);
        ld(LD_LB, 32'hFFFF_F800, 32'hFFFF_FFAB, 1'b0);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int gap;
        gap = (sel == 0) ? 2 : 3;
        req_we = 1'b0; req_addr = 32'h10; req_lc = LD_LW; req_sc = 2'b00;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ready_sel() === 1'b1) begin
                acc.push_back(cyc);
                push_exp(1'b0, 32'h10, 32'h0, 2'b00, 32'h80FF_1234, 1'b0);
            end
            tick();
        end
        req_valid = 1'b0;
        drain();
        checks++;
        if (acc.size() != 12 / gap) begin
            errors++;
            $display("FAIL b2b_accepts dut%0d got %0d want %0d", sel, acc.size(), 12 / gap);
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != gap) begin
                errors++;
                $display("FAIL b2b_gap dut%0d got %0d want %0d", sel, acc[i] - acc[i-1], gap);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 1;
        req_we = 1'b0; req_addr = 32'h10; req_lc = LD_LW; req_sc = 2'b00;
        req_valid = 1'b1;
        checks++;
        if (b2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ready got %b want 1", b2.req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (b2.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready got %b want 0", b2.req_ready);
        end
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        checks++;
        if (b2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b want 1", b2.req_ready);
        end
        repeat (3) tick();
        ld(LD_LW, 32'h10, 32'h80FF_1234, 1'b0);
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) st(ST_SW, 32'h100 + 32'(4 * w), $urandom(), 1'b0);
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [2:0]  lc;
            logic [1:0]  sc;
            logic [32:0] m;
            a  = ($urandom() & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 31)));
            lc = 3'($urandom_range(0, 7));
            sc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                st(sc, a, $urandom(), store_err(a, sc));
            end else begin
                m = model_load(sel, a, lc);
                ld(lc, a, m[31:0], m[32]);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            test_word_access();
            test_extend();
            test_errors();
            test_wrap();
            test_back_to_back();
            test_random();
        end
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving memory size in bytes (power of two, 4..65536).
REQ-002 SHALL have parameter RD_LAT, default 1, giving load latency in cycles after accept (legal values 1 or 2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, lane 0 = bits 7:0.
REQ-010 SHALL have port req_load_code  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 SHALL have port req_store_code  input  2  00 SB, 01 SH, 10 SW.
REQ-012 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port resp_rdata  output  32  load result, sign/zero-extended.
REQ-014 SHALL have port resp_err  output  1  misaligned or illegal code, valid with resp_valid.

Function
REQ-015 SHALL store bytes little-endian and index memory with req_addr[log2(DEPTH)-1:0]; upper address bits are ignored, so accesses wrap modulo DEPTH.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching we, address, data and code.
REQ-017 SHALL use states IDLE, WAIT, RESP: IDLE->RESP on accept when store, error or RD_LAT=1; IDLE->WAIT on accept of a legal load when RD_LAT=2; WAIT->RESP; RESP->IDLE unconditionally.
REQ-018 SHALL drive req_ready=1 only in IDLE, giving at most one outstanding request and no pipelining.
REQ-019 SHALL write the store byte lanes (SB 1, SH 2, SW 4) on the accept edge; resp_valid SHALL pulse in the following cycle with resp_rdata=0.
REQ-020 SHALL drive resp_valid in the cycle RD_LAT cycles after the accept edge for a legal load, with resp_rdata extended per the load code.
REQ-021 SHALL flag misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) and illegal codes (load 011/110/111; store 11) as errors: no memory write, resp_err=1, resp_rdata=0, response one cycle after accept.
REQ-022 SHALL make a store visible to any load accepted after it (read-after-write through the array, no stale data).
REQ-023 SHALL hold resp_rdata and resp_err stable only while resp_valid=1; both SHALL be 0 when resp_valid=0.
REQ-024 SHALL ignore req_* inputs whenever req_ready=0.
REQ-025 SHALL NOT apply backpressure on the response; the consumer samples resp_valid in its cycle.

Reset
REQ-026 SHALL on rst=1 immediately force state IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 SHALL abandon any in-flight load on reset mid-operation with no response; a store already written on its accept edge SHALL remain written.
REQ-028 SHALL NOT reset memory contents.

Structure
REQ-029 SHALL place load/store code constants and the state encoding in shared package lsu_pkg.
REQ-030 SHALL instantiate one sub-module, byte_ram (DEPTH bytes, four byte-lane write enables, registered read port).

Verification
REQ-031 SHALL cover: SW 0x80FF_1234 to addr 0x10, then LW 0x10 -> resp_rdata 0x80FF1234, resp_err 0, latency RD_LAT.
REQ-032 SHALL cover: after REQ-031, LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF.
REQ-033 SHALL cover: SH to addr 0x21 -> resp_err 1, and a subsequent LW 0x20 returns the prior contents unchanged.
REQ-034 SHALL cover: DEPTH=1024, SB 0xAB to addr 0x400 then LBU addr 0x000 -> 0x000000AB (wrap).
REQ-035 SHALL cover: rst asserted in WAIT (RD_LAT=2) -> no resp_valid; req_ready=1 the cycle after release.
REQ-036 SHALL cover: req_valid held high continuously -> one accept per 2 cycles (RD_LAT=1) or 3 cycles (RD_LAT=2).
